// File: rtl/riscv_multicycle.sv
// riscv_multicycle: multi-cycle RV subset core with one shared memory port.
// FSM steps fetch/decode/exec/mem/wb; memory waits are absorbed by req/ready.
module riscv_multicycle #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready,
    output logic [XLEN-1:0] pc,
    output logic            instr_retired,
    output logic            halted,
    output logic            illegal,
    input  logic [4:0]      dbg_raddr,
    output logic [XLEN-1:0] dbg_rdata
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LD, OP_ST, OP_BEQ
    } op_t;

    localparam logic [XLEN-1:0] FOUR = XLEN'(4);

    state_t          state;
    op_t             op;
    op_t             dec_op;
    logic            dec_ok;
    logic            is_ebreak;
    logic [31:0]     ir;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] alu_out;
    logic [XLEN-1:0] mdr;
    logic [XLEN-1:0] dec_imm;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] br_next;
    logic [XLEN-1:0] rf [32];

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;

    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];
    assign rd     = ir[11:7];

    assign is_ebreak = (ir == 32'h0010_0073);
    assign pc_plus4  = pc + FOUR;
    assign br_next   = (a == b) ? pc + imm : pc_plus4;

    assign dbg_rdata = (dbg_raddr == 5'd0) ? '0 : rf[dbg_raddr];

    // Retire on the last cycle of each instruction class.
    assign instr_retired = (state == S_EXEC && op == OP_BEQ)
                         || (state == S_WB)
                         || (state == S_MEM && op == OP_ST && mem_ready);

    // Instruction decode and immediate formation from IR.
    always_comb begin
        dec_op  = OP_ADD;
        dec_ok  = 1'b0;
        dec_imm = '0;
        case (opcode)
            7'b0110011: begin
                if (funct7 == 7'b0000000 && funct3 == 3'b000) begin
                    dec_op = OP_ADD;
                    dec_ok = 1'b1;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec_op = OP_SUB;
                    dec_ok = 1'b1;
                end else if (funct7 == 7'b0000000 && funct3 == 3'b111) begin
                    dec_op = OP_AND;
                    dec_ok = 1'b1;
                end else if (funct7 == 7'b0000000 && funct3 == 3'b110) begin
                    dec_op = OP_OR;
                    dec_ok = 1'b1;
                end
            end
            7'b0010011: begin
                dec_op  = OP_ADDI;
                dec_ok  = (funct3 == 3'b000);
                dec_imm = {{(XLEN-12){ir[31]}}, ir[31:20]};
            end
            7'b0000011: begin
                dec_op  = OP_LD;
                dec_ok  = 1'b1;
                dec_imm = {{(XLEN-12){ir[31]}}, ir[31:20]};
            end
            7'b0100011: begin
                dec_op  = OP_ST;
                dec_ok  = 1'b1;
                dec_imm = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
            end
            7'b1100011: begin
                dec_op  = OP_BEQ;
                dec_ok  = (funct3 == 3'b000);
                dec_imm = {{(XLEN-13){ir[31]}}, ir[31], ir[7],
                           ir[30:25], ir[11:8], 1'b0};
            end
            default: ;
        endcase
    end

    // ALU: register ops use B, everything else adds the immediate.
    always_comb begin
        case (op)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            default: alu_res = a + imm;
        endcase
    end

    // Main sequencer: state, PC, memory port, datapath regs, register file.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_FETCH;
            pc        <= RESET_PC;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= RESET_PC;
            mem_wdata <= '0;
            halted    <= 1'b0;
            illegal   <= 1'b0;
            ir        <= '0;
            op        <= OP_ADD;
            a         <= '0;
            b         <= '0;
            imm       <= '0;
            alu_out   <= '0;
            mdr       <= '0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_req && mem_ready) begin
                        ir      <= mem_rdata[31:0];
                        mem_req <= 1'b0;
                        state   <= S_DECODE;
                    end else begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc;
                    end
                end
                S_DECODE: begin
                    a   <= rf[ir[19:15]];
                    b   <= rf[ir[24:20]];
                    imm <= dec_imm;
                    op  <= dec_op;
                    if (is_ebreak) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else if (!dec_ok) begin
                        halted  <= 1'b1;
                        illegal <= 1'b1;
                        state   <= S_HALT;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    alu_out <= alu_res;
                    if (op == OP_BEQ) begin
                        pc       <= br_next;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= br_next;
                        state    <= S_FETCH;
                    end else if (op == OP_LD || op == OP_ST) begin
                        mem_req   <= 1'b1;
                        mem_we    <= (op == OP_ST);
                        mem_addr  <= alu_res;
                        mem_wdata <= b;
                        state     <= S_MEM;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        mem_we <= 1'b0;
                        if (op == OP_ST) begin
                            pc       <= pc_plus4;
                            mem_addr <= pc_plus4;
                            state    <= S_FETCH;
                        end else begin
                            mdr     <= mem_rdata;
                            mem_req <= 1'b0;
                            state   <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    if (rd != 5'd0) begin
                        rf[rd] <= (op == OP_LD) ? mdr : alu_out;
                    end
                    pc       <= pc_plus4;
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= pc_plus4;
                    state    <= S_FETCH;
                end
                default: ;
            endcase
        end
    end

endmodule
